onehot_sequencer: RTL and testbench

Parametrised one-hot position sequencer for the DepthBdd datapath: drives per-position enables for multi-cycle operations whose cycle count is chosen at run time. Generalises the fixed-length one-hot counters with a runtime length, three run modes (one-shot, step, free-run), hold, abort and a completion pulse. Sits between the depth controller, which issues start/step/abort, and the pipelined units that consume the one-hot position.

---
 rtl/onehot_seq_pkg.sv | 26 ++
 rtl/onehot_sequencer_if.sv | 48 ++++
 rtl/onehot_ring.sv | 43 ++++
 rtl/onehot_sequencer.sv | 138 +++++++++++++
 tb/tb_onehot_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/onehot_seq_pkg.sv
// Shared definitions for the one-hot position sequencer: run-mode codes,
// FSM state encoding and the length clamp / mode normalisation helpers.
package onehot_seq_pkg;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_STEP    = 2'b01;
  localparam logic [1:0] MODE_FREERUN = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Clamp a requested run length into [2, max_len].
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len < 2) return 2;
    if (len > max_len) return max_len;
    return len;
  endfunction

  // The reserved mode code 11 behaves as one-shot.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_ONESHOT : m;
  endfunction

endpackage

// File: rtl/onehot_sequencer_if.sv
// Control/status bundle between the depth controller (master) and the
// one-hot sequencer (slave).
//   start/mode/length/step/hold/abort : controller -> sequencer
//   counter/running/last/wrap/done    : sequencer -> consumers
//   wrap_count                        : only with ONEHOT_SEQ_WRAP_COUNT_EN
interface onehot_sequencer_if #(
  parameter int unsigned NUMBER = 4,
  parameter int unsigned LEN_W  = 3,
  parameter int unsigned WRAP_W = 8
);

  logic              start;
  logic [1:0]        mode;
  logic [LEN_W-1:0]  length;
  logic              step;
  logic              hold;
  logic              abort;
  logic [NUMBER-1:0] counter;
  logic              running;
  logic              last;
  logic              wrap;
  logic              done;
`ifdef ONEHOT_SEQ_WRAP_COUNT_EN
  logic [WRAP_W-1:0] wrap_count;
`endif

  // Reject configurations the sequencer cannot represent.
  if (NUMBER < 2 || (NUMBER >> LEN_W) != 0 || WRAP_W < 1) begin : g_bad_cfg
    $error("onehot_sequencer_if: invalid NUMBER/LEN_W/WRAP_W");
  end

  modport master (
    output start, mode, length, step, hold, abort,
`ifdef ONEHOT_SEQ_WRAP_COUNT_EN
    input  wrap_count,
`endif
    input  counter, running, last, wrap, done
  );

  modport slave (
    input  start, mode, length, step, hold, abort,
`ifdef ONEHOT_SEQ_WRAP_COUNT_EN
    output wrap_count,
`endif
    output counter, running, last, wrap, done
  );

endinterface

// File: rtl/onehot_ring.sv
// Rotate-by-one one-hot register with enable, runtime wrap point and
// synchronous load-to-1. Knows nothing about run modes.
//   clk, reset : clock, synchronous active-high reset (loads 1)
//   en         : advance one position
//   load_one   : return to bit 0 (wins over en)
//   wrap_len   : active positions; bit wrap_len-1 returns to bit 0
//   q          : registered one-hot position
//   at_end_c   : q currently sits on bit wrap_len-1
module onehot_ring #(
  parameter int unsigned N     = 4,
  parameter int unsigned LEN_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load_one,
  input  logic [LEN_W-1:0] wrap_len,
  output logic [N-1:0]     q,
  output logic             at_end_c
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] end_mask;

  // Single-bit mask marking the wrap position.
  always_comb begin
    end_mask = '0;
    for (int i = 0; i < int'(N); i++) begin
      end_mask[i] = (LEN_W'(i + 1) == wrap_len);
    end
    at_end_c = |(q & end_mask);
  end

  always_ff @(posedge clk) begin
    if (reset || load_one) begin
      q <= ONE;
    end else if (en) begin
      q <= at_end_c ? ONE : {q[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/onehot_sequencer.sv
// One-hot position sequencer with runtime length and one-shot / step /
// free-run modes, hold, abort and a one-shot completion pulse.
// Optional feature macro: ONEHOT_SEQ_WRAP_COUNT_EN adds a saturating
// wrap counter (bus.wrap_count), cleared on start, abort and reset.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : onehot_sequencer_if.slave (start/mode/length/step/hold/abort in;
//           counter/running/last/wrap/done[/wrap_count] out)
// running, last and wrap are combinational; counter, done, wrap_count are
// registered.
module onehot_sequencer
  import onehot_seq_pkg::*;
#(
  parameter int unsigned NUMBER = 4,
  parameter int unsigned LEN_W  = 3,
  parameter int unsigned WRAP_W = 8
) (
  input  logic clk,
  input  logic reset,
  onehot_sequencer_if.slave bus
);

  if (NUMBER < 2 || (NUMBER >> LEN_W) != 0 || WRAP_W < 1) begin : g_bad_cfg
    $error("onehot_sequencer: invalid NUMBER/LEN_W/WRAP_W");
  end

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              done_q, done_d;
  logic [NUMBER-1:0] counter_q;
  logic              at_end;

  logic              launch_c, running_c, advance_c, last_c, wrap_c, ring_load_c;
  logic [1:0]        eff_mode_c;
  logic [LEN_W-1:0]  eff_len_c;

`ifdef ONEHOT_SEQ_WRAP_COUNT_EN
  logic [WRAP_W-1:0] wc_q, wc_d;
`endif

  // In the start cycle the live (clamped) request governs; afterwards the latched copy.
  assign launch_c   = (state_q == IDLE) && bus.start && !bus.abort;
  assign running_c  = (state_q == RUN) || launch_c;
  assign eff_mode_c = (state_q == RUN) ? mode_q : norm_mode(bus.mode);
  assign eff_len_c  = (state_q == RUN) ? len_q
                                       : LEN_W'(clamp_len(32'(bus.length), NUMBER));

  onehot_ring #(.N(NUMBER), .LEN_W(LEN_W)) u_ring (
    .clk      (clk),
    .reset    (reset),
    .en       (advance_c),
    .load_one (ring_load_c),
    .wrap_len (eff_len_c),
    .q        (counter_q),
    .at_end_c (at_end)
  );

  // Next-state and advance/wrap decode.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    done_d      = 1'b0;
    advance_c   = 1'b0;
    last_c      = 1'b0;
    wrap_c      = 1'b0;
    ring_load_c = 1'b0;
`ifdef ONEHOT_SEQ_WRAP_COUNT_EN
    wc_d        = wc_q;
`endif

    // abort is folded in here so it beats any advance.
    advance_c = running_c && !bus.hold && !bus.abort &&
                ((eff_mode_c == MODE_STEP) ? bus.step : 1'b1);
    last_c    = running_c && at_end;
    wrap_c    = last_c && advance_c;

    case (state_q)
      IDLE: begin
        if (launch_c) begin
          state_d = RUN;
          mode_d  = norm_mode(bus.mode);
          len_d   = eff_len_c;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (wrap_c && eff_mode_c == MODE_ONESHOT) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    done_d      = wrap_c && (eff_mode_c == MODE_ONESHOT);
    ring_load_c = bus.abort || done_d;

`ifdef ONEHOT_SEQ_WRAP_COUNT_EN
    if (bus.abort || launch_c) begin
      wc_d = '0;
    end else if (wrap_c && wc_q != '1) begin
      wc_d = wc_q + WRAP_W'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_ONESHOT;
      len_q   <= LEN_W'(NUMBER);
      done_q  <= 1'b0;
`ifdef ONEHOT_SEQ_WRAP_COUNT_EN
      wc_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      done_q  <= done_d;
`ifdef ONEHOT_SEQ_WRAP_COUNT_EN
      wc_q    <= wc_d;
`endif
    end
  end

  assign bus.counter = counter_q;
  assign bus.running = running_c;
  assign bus.last    = last_c;
  assign bus.wrap    = wrap_c;
  assign bus.done    = done_q;
`ifdef ONEHOT_SEQ_WRAP_COUNT_EN
  assign bus.wrap_count = wc_q;
`endif

endmodule

// File: tb/tb_onehot_sequencer.sv
// Scoreboard bench for onehot_sequencer: the driver applies one input vector
// per cycle, predicts that cycle's outputs from a position/length model and
// queues them; the monitor pops and compares on the falling edge.
module tb_onehot_sequencer;

  localparam int unsigned NUMBER = 4;
  localparam int unsigned LEN_W  = 3;
`ifdef ONEHOT_SEQ_WRAP_COUNT_EN
  localparam int unsigned WW = 2;
`else
  localparam int unsigned WW = 8;
`endif

  logic clk;
  logic reset;

  onehot_sequencer_if #(.NUMBER(NUMBER), .LEN_W(LEN_W), .WRAP_W(WW)) bus ();

  onehot_sequencer #(.NUMBER(NUMBER), .LEN_W(LEN_W), .WRAP_W(WW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int counter;
    bit running;
    bit last;
    bit wrap;
    bit done;
    int wc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc_no = 0;

  // Reference model: position index, not a bit vector.
  bit m_active = 0;
  int m_pos    = 0;
  int m_len    = NUMBER;
  int m_mode   = 0;
  bit m_done   = 0;
  int m_wc     = 0;

  function automatic int clamp_m(input int l);
    if (l < 2) return 2;
    if (l > int'(NUMBER)) return int'(NUMBER);
    return l;
  endfunction

  task automatic chk(input string name, input int cyc, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
  endtask

  task automatic cyc(input bit st, input int md, input int ln, input bit sp,
                     input bit hd, input bit ab, input bit rs);
    exp_t e;
    int   elen, emode;
    bit   launch, run, adv, lst, wr;
    @(posedge clk);
    #1;
    cyc_no++;
    bus.start  = st;
    bus.mode   = 2'(md);
    bus.length = LEN_W'(ln);
    bus.step   = sp;
    bus.hold   = hd;
    bus.abort  = ab;
    reset      = rs;

    launch = !m_active && st && !ab;
    run    = m_active || launch;
    elen   = m_active ? m_len : clamp_m(int'(bus.length));
    emode  = m_active ? m_mode : ((int'(bus.mode) == 3) ? 0 : int'(bus.mode));
    adv    = run && !hd && !ab && ((emode == 1) ? sp : 1'b1);
    lst    = run && (m_pos == elen - 1);
    wr     = lst && adv;

    e.cyc     = cyc_no;
    e.counter = 1 << m_pos;
    e.running = run;
    e.last    = lst;
    e.wrap    = wr;
    e.done    = m_done;
    e.wc      = m_wc;
    q.push_back(e);

    if (rs || ab) begin
      m_active = 0; m_pos = 0; m_done = 0; m_wc = 0;
      if (rs) begin m_mode = 0; m_len = NUMBER; end
    end else begin
      m_done = wr && (emode == 0);
      if (launch) begin
        m_active = 1; m_len = elen; m_mode = emode; m_wc = 0;
      end
      if (adv) m_pos = wr ? 0 : m_pos + 1;
      if (wr && emode == 0) m_active = 0;
      if (wr && m_wc < (1 << WW) - 1) m_wc++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one output set per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("counter", e.cyc, int'(bus.counter), e.counter);
        chk("running", e.cyc, int'(bus.running), int'(e.running));
        chk("last",    e.cyc, int'(bus.last),    int'(e.last));
        chk("wrap",    e.cyc, int'(bus.wrap),    int'(e.wrap));
        chk("done",    e.cyc, int'(bus.done),    int'(e.done));
`ifdef ONEHOT_SEQ_WRAP_COUNT_EN
        chk("wrap_count", e.cyc, int'(bus.wrap_count), e.wc);
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.start = 0; bus.mode = 0; bus.length = 0;
    bus.step = 0; bus.hold = 0; bus.abort = 0;

    // Reset state, then one-shot length 3.
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(2);
    cyc(1, 0, 3, 0, 0, 0, 0);
    idle(5);

    // Step mode length 4, six spaced pulses, then abort.
    cyc(1, 1, 4, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 1, 0, 0, 0);
      idle(2);
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // Free-run length 2 with a 3-cycle hold at position 1, then abort.
    cyc(1, 2, 2, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0, 0);
    idle(3);
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // Clamping both ends, mode 11, and start together with abort.
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(4);
    cyc(1, 3, 7, 0, 0, 0, 0);
    idle(6);
    cyc(1, 0, 3, 0, 0, 1, 0);
    idle(2);

    // Reset mid one-shot, then relaunch in the done cycle.
    cyc(1, 0, 4, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    cyc(1, 0, 2, 0, 0, 0, 0);
    idle(1);
    cyc(1, 0, 3, 0, 0, 0, 0);
    idle(4);

    // Free-run length 2 long enough to saturate a small wrap counter.
    cyc(1, 2, 2, 0, 0, 0, 0);
    idle(10);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 2, 0, 0, 0, 0);
    idle(3);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 7),
          $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
          $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);
    end

    repeat (3) @(negedge clk);
    chk("drain", cyc_no, q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
